mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N, default 4, operand width of the shared sequential signed multiplier.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_a  input  NREQ*N  packed signed multiplicands; slice [i*N +: N] belongs to requester i.
REQ-008 req_b  input  NREQ*N  packed signed multipliers; same packing as req_a.
REQ-009 rsp_valid  output  1  response valid.
REQ-010 rsp_ready  input  1  response accept.
REQ-011 rsp_id  output  clog2(NREQ)  index of the requester that owns the response.
REQ-012 rsp_product  output  2N  signed product.
REQ-013 mul_start  output  1  one-cycle load pulse to the multiplier.
REQ-014 mul_multiplicand, mul_multiplier  output  N each  operands to the multiplier.
REQ-015 mul_product  input  2N  multiplier result.
REQ-016 mul_done  input  1  multiplier completion; cleared by the multiplier on the edge sampling mul_start, set N edges later, held until the next start.

Function
REQ-017 The FSM SHALL have states IDLE, START, WAIT and RESP, encoded one-hot or binary.
REQ-018 IDLE: when any req_valid bit is set, the block SHALL assert req_ready for exactly the granted index for one cycle.
- Handshake completes on that edge.
- Operands and index are latched on that edge.
- FSM moves to START.
REQ-019 Grant SHALL be round-robin.
- Search starts at last_grant+1 modulo NREQ.
- last_grant updates only on a completed request handshake.
REQ-020 START: mul_start SHALL be 1 for this single cycle with the latched operands on mul_multiplicand/mul_multiplier; FSM moves to WAIT.
REQ-021 mul_multiplicand/mul_multiplier SHALL hold the latched operands from START until the response handshake.
REQ-022 WAIT: mul_done SHALL be ignored in the START cycle only.
- When mul_done=1 in WAIT, mul_product is captured into rsp_product.
- FSM moves to RESP.
REQ-023 Latency: rsp_valid SHALL first be high after the (N+2)th rising edge following the request-handshake edge (6 for N=4).
REQ-024 RESP: rsp_valid=1 with rsp_id and rsp_product stable until rsp_valid&rsp_ready completes; FSM then returns to IDLE.
REQ-025 req_ready SHALL be 0 in START, WAIT and RESP; exactly one operation is in flight.
REQ-026 Consecutive operations: a request pending in IDLE SHALL be granted in the first IDLE cycle after the response handshake (one idle cycle minimum between ops).
REQ-027 A requester deasserting req_valid before its grant SHALL be skipped; there is no request storage.
REQ-028 Operand data SHALL pass unmodified; the sign is interpreted only by the multiplier.

Reset
REQ-029 On rst the block SHALL immediately set:
- FSM=IDLE, last_grant=NREQ-1 (so requester 0 has first priority).
- req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0.
- mul_start=0, mul_multiplicand=0, mul_multiplier=0.
REQ-030 Reset mid-operation SHALL abandon the in-flight operation with no response; the multiplier is reset by the same rst at top level.

Configuration
REQ-031 With macro MULT_ARB_STATS_EN defined:
- Port stat_ops output 16 SHALL count completed response handshakes.
- It wraps 0xFFFF->0 and resets to 0.
- Without the macro the port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-032 N=4, req0 a=3 b=-2 -> req_ready[0] one cycle; rsp_valid 6 cycles later, rsp_id=0, rsp_product=8'hFA.
REQ-033 After reset, req_valid=4'b1111 held (a=i+1, b=2) -> grant order 0,1,2,3,0; products 2,4,6,8.
REQ-034 Requester 1 just served, then req_valid=4'b0101 -> requester 2 granted before 0.
REQ-035 rsp_ready=0 for 5 cycles in RESP, a=-8 b=-8 -> rsp_valid/rsp_product=8'h40 stable; no req_ready; accept on 6th cycle.
REQ-036 rst pulsed in WAIT -> all outputs 0 asynchronously; no response; next request (req3 a=7 b=7) granted normally -> 8'h31.
REQ-037 MULT_ARB_STATS_EN defined, 3 completed ops -> stat_ops=3; without macro -> bench compiles without the port.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin front end for a shared sequential signed multiplier: grant -> result in N+2 cycles, one op in flight.
// Response held until rsp_ready; req_ready only in IDLE. Define MULT_ARB_STATS_EN to add the stat_ops counter.
module mult_arbiter #(
  parameter int N    = 4,
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*N-1:0]         req_a,
  input  logic [NREQ*N-1:0]         req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*N-1:0]            rsp_product,
  output logic                      mul_start,
  output logic [N-1:0]              mul_multiplicand,
  output logic [N-1:0]              mul_multiplier,
  input  logic [2*N-1:0]            mul_product,
`ifdef MULT_ARB_STATS_EN
  output logic [15:0]               stat_ops,
`endif
  input  logic                      mul_done
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic [IW:0]     cand;
  logic [N-1:0]    a_arr [NREQ];
  logic [N-1:0]    b_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*N +: N];
      b_arr[i] = req_b[i*N +: N];
    end
  end

  // Search order last_grant+1, +2, ... wrapping modulo NREQ; first valid wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (!grant_vld && req_valid[cand[IW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  // Grant follows the live req_valid so a requester that drops out is never accepted.
  assign req_ready = (state == IDLE && !rst && grant_vld) ? (NREQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      last_grant       <= IW'(NREQ-1);
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_product      <= '0;
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            last_grant       <= grant_idx;
            rsp_id           <= grant_idx;
            mul_multiplicand <= a_arr[grant_idx];
            mul_multiplier   <= b_arr[grant_idx];
            mul_start        <= 1'b1;
            state            <= START;
          end
        end
        START: begin
          // mul_done may still be high from the previous op here, so it is not looked at.
          mul_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stat_ops <= '0;
    else if (state == RESP && rsp_ready)
      stat_ops <= stat_ops + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural N-cycle multiplier attached.
module tb_mult_arbiter;
  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int IW   = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*N-1:0]    req_a;
  logic [NREQ*N-1:0]    req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IW-1:0]        rsp_id;
  logic [2*N-1:0]       rsp_product;
  logic                 mul_start;
  logic [N-1:0]         mul_multiplicand;
  logic [N-1:0]         mul_multiplier;
  logic [2*N-1:0]       mul_product;
  logic                 mul_done;
`ifdef MULT_ARB_STATS_EN
  logic [15:0]          stat_ops;
`endif

  mult_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product),
    .mul_start(mul_start),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_product(mul_product),
`ifdef MULT_ARB_STATS_EN
    .stat_ops(stat_ops),
`endif
    .mul_done(mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand tables, packed onto req_a/req_b.
  logic [N-1:0] ta [NREQ];
  logic [N-1:0] tbv[NREQ];
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = ta[i];
      req_b[i*N +: N] = tbv[i];
    end
  end

  // Behavioural multiplier: done drops on the start edge, rises N edges later.
  logic signed [N-1:0]   ma, mb;
  logic signed [2*N-1:0] mea, meb;
  int                    mcnt;
  assign mea = ma;
  assign meb = mb;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_done <= 1'b0; mcnt <= 0; ma <= '0; mb <= '0; mul_product <= '0;
    end else if (mul_start) begin
      mul_done <= 1'b0; mcnt <= N; ma <= mul_multiplicand; mb <= mul_multiplier;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mul_done    <= 1'b1;
        mul_product <= mea * meb;
      end
    end
  end

  typedef struct packed {
    logic [IW-1:0]  id;
    logic [2*N-1:0] prod;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic signed [N-1:0]   sa, sbb;
  logic signed [2*N-1:0] xa, xb;
  int n_checks = 0;
  int n_fail   = 0;
  int ops_since_rst = 0;

  always @(posedge rst) begin
    sb.delete();
    ops_since_rst = 0;
  end

  // Monitor: push on request handshake, pop and compare on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sa  = ta[i];
          sbb = tbv[i];
          xa  = sa;
          xb  = sbb;
          mon_e.id   = IW'(i);
          mon_e.prod = xa * xb;
          sb.push_back(mon_e);
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_rsp id=%0d product=%h with empty scoreboard", rsp_id, rsp_product);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_id !== mon_e.id || rsp_product !== mon_e.prod) begin
            n_fail++;
            $display("FAIL sb_rsp got id=%0d product=%h expected id=%0d product=%h",
                     rsp_id, rsp_product, mon_e.id, mon_e.prod);
          end
        end
        ops_since_rst++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin ta[i] = '0; tbv[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic wait_grant(output int w);
    w = 0;
    while (req_ready == '0 && w < 40) begin step(); w++; end
    n_checks++;
    if (req_ready == '0) begin
      n_fail++;
      $display("FAIL grant_timeout req_ready=%b expected a grant", req_ready);
    end
  endtask

  task automatic wait_rsp();
    int w = 0;
    while (!rsp_valid && w < 40) begin step(); w++; end
    n_checks++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL rsp_timeout rsp_valid=%b expected 1", rsp_valid);
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb.size() != 0 && w < 40) begin step(); w++; end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs req_ready=%b rsp_valid=%b expected 0 0", req_ready, rsp_valid);
    end
    n_checks++;
    if (rsp_id !== '0 || rsp_product !== '0) begin
      n_fail++; $display("FAIL reset_rsp id=%0d product=%h expected 0 00", rsp_id, rsp_product);
    end
    n_checks++;
    if (mul_start !== 1'b0 || mul_multiplicand !== '0 || mul_multiplier !== '0) begin
      n_fail++; $display("FAIL reset_mul start=%b a=%h b=%h expected 0 0 0", mul_start, mul_multiplicand, mul_multiplier);
    end
  endtask

  task automatic test_single();
    ta[0] = 4'd3; tbv[0] = 4'hE; rsp_ready = 1'b0;
    req_valid = 4'b0001; #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_grant req_ready=%b expected 0001", req_ready);
    end
    step(); req_valid = '0; #1;
    n_checks++;
    if (mul_start !== 1'b1 || mul_multiplicand !== 4'd3 || mul_multiplier !== 4'hE) begin
      n_fail++; $display("FAIL single_start start=%b a=%h b=%h expected 1 3 e", mul_start, mul_multiplicand, mul_multiplier);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++;
      if (rsp_valid !== (k == 6)) begin
        n_fail++; $display("FAIL single_latency edge=%0d rsp_valid=%b expected %b", k, rsp_valid, (k == 6));
      end
    end
    n_checks++;
    if (mul_start !== 1'b0 || mul_multiplicand !== 4'd3 || mul_multiplier !== 4'hE) begin
      n_fail++; $display("FAIL single_hold start=%b a=%h b=%h expected 0 3 e", mul_start, mul_multiplicand, mul_multiplier);
    end
    n_checks++;
    if (rsp_id !== 2'd0 || rsp_product !== 8'hFA) begin
      n_fail++; $display("FAIL single_rsp id=%0d product=%h expected 0 fa", rsp_id, rsp_product);
    end
    rsp_ready = 1'b1;
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_release rsp_valid=%b expected 0", rsp_valid);
    end
    wait_drain();
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin ta[i] = 4'(i + 1); tbv[i] = 4'd2; end
    rsp_ready = 1'b1; req_valid = 4'b1111; #1;
    for (int g = 0; g < 5; g++) begin
      wait_grant(w);
      n_checks++;
      if (req_ready !== (4'b0001 << (g % 4))) begin
        n_fail++; $display("FAIL rr_order grant%0d req_ready=%b expected %b", g, req_ready, 4'b0001 << (g % 4));
      end
      if (g > 0) begin
        n_checks++;
        if (w !== 7) begin
          n_fail++; $display("FAIL rr_gap grant%0d cycles=%0d expected 7", g, w);
        end
      end
      step();
    end
    req_valid = '0;
    wait_drain();
  endtask

  task automatic test_skip();
    int w;
    ta[1] = 4'd5; tbv[1] = 4'd3; ta[2] = 4'hF; tbv[2] = 4'd7; ta[0] = 4'd4; tbv[0] = 4'hC;
    ta[3] = 4'd1; tbv[3] = 4'd1;
    rsp_ready = 1'b1; req_valid = 4'b0010; #1;
    wait_grant(w);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL skip_prep req_ready=%b expected 0010", req_ready);
    end
    step(); req_valid = '0;
    wait_drain();
    step();
    req_valid = 4'b0101; #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL skip_rr req_ready=%b expected 0100", req_ready);
    end
    step();
    // Requester 3 pulses while busy and must not be remembered.
    req_valid = 4'b1101; step(); step();
    req_valid = 4'b0101; #1;
    wait_grant(w);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL skip_dropped req_ready=%b expected 0001", req_ready);
    end
    step(); req_valid = '0;
    wait_drain();
  endtask

  task automatic test_backpressure();
    int w;
    ta[0] = 4'h8; tbv[0] = 4'h8; ta[3] = 4'd2; tbv[3] = 4'd3;
    rsp_ready = 1'b0; req_valid = 4'b0001; #1;
    wait_grant(w);
    step(); req_valid = 4'b1000;
    wait_rsp();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_product !== 8'h40 || rsp_id !== 2'd0) begin
        n_fail++; $display("FAIL bp_hold cycle=%0d valid=%b id=%0d product=%h expected 1 0 40", c, rsp_valid, rsp_id, rsp_product);
      end
      n_checks++;
      if (req_ready !== '0) begin
        n_fail++; $display("FAIL bp_no_grant cycle=%0d req_ready=%b expected 0000", c, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL bp_accept rsp_valid=%b req_ready=%b expected 0 1000", rsp_valid, req_ready);
    end
    step(); req_valid = '0;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int w;
    int seen;
    ta[1] = 4'd1; tbv[1] = 4'd1; rsp_ready = 1'b1;
    req_valid = 4'b0010; #1;
    wait_grant(w);
    step(); req_valid = '0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_product !== '0 ||
        mul_start !== 1'b0 || mul_multiplicand !== '0 || mul_multiplier !== '0) begin
      n_fail++; $display("FAIL rst_async rdy=%b vld=%b id=%0d prod=%h start=%b a=%h b=%h expected all 0",
                         req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_multiplicand, mul_multiplier);
    end
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (rsp_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL rst_abandon rsp_valid cycles=%0d expected 0", seen);
    end
    ta[3] = 4'd7; tbv[3] = 4'd7; rsp_ready = 1'b0;
    req_valid = 4'b1000; #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL rst_regrant req_ready=%b expected 1000", req_ready);
    end
    step(); req_valid = '0;
    wait_rsp();
    n_checks++;
    if (rsp_id !== 2'd3 || rsp_product !== 8'h31) begin
      n_fail++; $display("FAIL rst_rsp id=%0d product=%h expected 3 31", rsp_id, rsp_product);
    end
    rsp_ready = 1'b1;
    step();
    wait_drain();
  endtask

  task automatic test_stats();
    int w;
    ta[0] = 4'd2; tbv[0] = 4'd2; ta[1] = 4'd3; tbv[1] = 4'd3;
    rsp_ready = 1'b1; req_valid = 4'b0011; #1;
    for (int g = 0; g < 2; g++) begin
      wait_grant(w);
      step();
    end
    req_valid = '0;
    wait_drain();
    step();
    n_checks++;
    if (ops_since_rst !== 3) begin
      n_fail++; $display("FAIL stats_ops_seen count=%0d expected 3", ops_since_rst);
    end
`ifdef MULT_ARB_STATS_EN
    n_checks++;
    if (stat_ops !== 16'd3) begin
      n_fail++; $display("FAIL stats_counter stat_ops=%0d expected 3", stat_ops);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin ta[i] = '0; tbv[i] = '0; end
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_backpressure();
    test_reset_mid();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
